lzd_denorm: RTL and testbench

//  Inverse of the leading-zero detect path: takes a normalized mantissa plus the shift code

---
 rtl/lzd_pkg.sv | 20 ++
 rtl/lzd_shift_stage.sv | 25 ++
 rtl/lzd_denorm.sv | 137 +++++++++++++
 tb/tb_lzd_denorm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lzd_pkg.sv
// lzd_pkg: shared defaults and helpers for the leading-zero denormalizer.
//   LZD_W / LZD_SW : default mantissa width and shift-code width (W == 2**SW)
//   RND_TRUNC      : drop shifted-out bits
//   RND_RNE        : round-to-nearest-even on shifted-out bits
//   lzd_clog2      : ceil(log2(n)), used to derive the code width from W
package lzd_pkg;

   localparam int LZD_W     = 8;
   localparam int LZD_SW    = 3;
   localparam int RND_TRUNC = 0;
   localparam int RND_RNE   = 1;

   function automatic int lzd_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/lzd_shift_stage.sv
// lzd_shift_stage: one barrel-shifter stage, fixed logical right shift by SH when enabled.
//   i_data  [DW]  operand
//   i_en          apply the shift
//   o_data  [DW]  shifted (or passed-through) operand
//   o_drop        OR of the bits pushed out below bit 0 (0 when not enabled)
module lzd_shift_stage #(
   parameter int DW = 9,
   parameter int SH = 1
) (
   input  logic [DW-1:0] i_data,
   input  logic          i_en,
   output logic [DW-1:0] o_data,
   output logic          o_drop
);

   always_comb begin
      o_data = i_data;
      o_drop = 1'b0;
      if (i_en) begin
         o_data = i_data >> SH;
         o_drop = |i_data[SH-1:0];
      end
   end

endmodule

// File: rtl/lzd_denorm.sv
// lzd_denorm: re-inserts the leading zeros removed by the normalize path, i.e. a logical
// right shift of the mantissa by the LZ code, with sticky and optional RNE rounding.
// Two-stage pipeline with valid/ready on both sides.
//   clk, rst_n              clock, async active-low reset
//   i_in_valid/o_in_ready   input handshake
//   i_in_mant [W]           normalized mantissa
//   i_in_shift [SW]         leading-zero count to re-insert
//   i_in_zero               operand is all-zero; forces a zero result
//   o_out_valid/i_out_ready output handshake
//   o_out_data [W]          denormalized (optionally rounded) result
//   o_out_sticky            OR of every bit shifted out, guard included, before rounding
//   o_out_zero              result is the forced-zero case
module lzd_denorm
   import lzd_pkg::*;
#(
   parameter int W     = LZD_W,
   parameter int SW    = lzd_clog2(W),
   parameter int ROUND = RND_TRUNC
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [W-1:0]  i_in_mant,
   input  logic [SW-1:0] i_in_shift,
   input  logic          i_in_zero,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [W-1:0]  o_out_data,
   output logic          o_out_sticky,
   output logic          o_out_zero
);

   // One extra LSB below the mantissa carries the guard bit through every stage;
   // anything falling below it is folded into the sticky OR.
   localparam int DW = W + 1;

   logic          r_s1_valid;
   logic [DW-1:0] r_s1_data;
   logic [SW-2:0] r_s1_code;
   logic          r_s1_zero;
   logic          r_s1_sticky;

   logic          r_s2_valid;
   logic [W-1:0]  r_s2_data;
   logic          r_s2_sticky;
   logic          r_s2_zero;

   logic          w_s1_go;
   logic          w_in_ready;
   logic [DW-1:0] w_s1_data;
   logic          w_s1_drop;

   assign w_s1_go    = !r_s2_valid || i_out_ready;
   assign w_in_ready = !r_s1_valid || w_s1_go;

   // Stage 1: MSB of the code, shift by W/2.
   lzd_shift_stage #(.DW(DW), .SH(W/2)) u_stage_hi (
      .i_data (i_in_mant << 1 | DW'(0)),
      .i_en   (i_in_shift[SW-1]),
      .o_data (w_s1_data),
      .o_drop (w_s1_drop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_code   <= '0;
         r_s1_zero   <= 1'b0;
         r_s1_sticky <= 1'b0;
      end else begin
         if (w_in_ready) r_s1_valid <= i_in_valid;
         if (w_in_ready && i_in_valid) begin
            r_s1_data   <= w_s1_data;
            r_s1_code   <= i_in_shift[SW-2:0];
            r_s1_zero   <= i_in_zero;
            r_s1_sticky <= w_s1_drop;
         end
      end
   end

   // Stage 2: remaining code bits, LSB first.
   logic [DW-1:0] w_chain [SW];
   logic [SW-2:0] w_drop;

   assign w_chain[0] = r_s1_data;

   genvar k;
   generate
      for (k = 0; k < SW-1; k++) begin : g_lo
         lzd_shift_stage #(.DW(DW), .SH(1 << k)) u_stage_lo (
            .i_data (w_chain[k]),
            .i_en   (r_s1_code[k]),
            .o_data (w_chain[k+1]),
            .o_drop (w_drop[k])
         );
      end
   endgenerate

   logic [W-1:0] w_res;
   logic         w_guard;
   logic         w_stk_lo;
   logic         w_inc;
   logic [W-1:0] w_rnd;

   assign w_res    = w_chain[SW-1][DW-1:1];
   assign w_guard  = w_chain[SW-1][0];
   assign w_stk_lo = r_s1_sticky | (|w_drop);
   // Guard is only ever set for shift>=1, so the result is at most 2**(W-1)-1
   // before the increment and the add cannot carry out.
   assign w_inc    = (ROUND == RND_RNE) && w_guard && (w_stk_lo || w_res[0]);
   assign w_rnd    = w_res + {{(W-1){1'b0}}, w_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid  <= 1'b0;
         r_s2_data   <= '0;
         r_s2_sticky <= 1'b0;
         r_s2_zero   <= 1'b0;
      end else begin
         if (w_s1_go) r_s2_valid <= r_s1_valid;
         if (w_s1_go && r_s1_valid) begin
            r_s2_data   <= r_s1_zero ? '0 : w_rnd;
            r_s2_sticky <= r_s1_zero ? 1'b0 : (w_guard | w_stk_lo);
            r_s2_zero   <= r_s1_zero;
         end
      end
   end

   assign o_in_ready   = w_in_ready;
   assign o_out_valid  = r_s2_valid;
   assign o_out_data   = r_s2_data;
   assign o_out_sticky = r_s2_sticky;
   assign o_out_zero   = r_s2_zero;

endmodule

// File: tb/tb_lzd_denorm.sv
// tb_lzd_denorm: drives a truncating and an RNE instance from the same stimulus and
// checks both against an arithmetic model through a scoreboard queue.
module tb_lzd_denorm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_mant = '0;
   logic [2:0] in_shift = '0;
   logic       in_zero = 1'b0;
   logic       out_ready = 1'b1;

   logic       rdy0, vld0, stk0, zro0;
   logic       rdy1, vld1, stk1, zro1;
   logic [7:0] dat0, dat1;

   always #5 clk = ~clk;

   lzd_denorm #(.W(8), .SW(3), .ROUND(0)) d0 (
      .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy0),
      .i_in_mant(in_mant), .i_in_shift(in_shift), .i_in_zero(in_zero),
      .o_out_valid(vld0), .i_out_ready(out_ready), .o_out_data(dat0),
      .o_out_sticky(stk0), .o_out_zero(zro0));

   lzd_denorm #(.W(8), .SW(3), .ROUND(1)) d1 (
      .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy1),
      .i_in_mant(in_mant), .i_in_shift(in_shift), .i_in_zero(in_zero),
      .o_out_valid(vld1), .i_out_ready(out_ready), .o_out_data(dat1),
      .o_out_sticky(stk1), .o_out_zero(zro1));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0] d_tr;
      logic [7:0] d_rn;
      logic       s;
      logic       z;
   } exp_t;

   // Plain arithmetic: quotient by 2**sh, remainder compared against one half ulp.
   function automatic exp_t model(input logic [7:0] m, input int sh, input logic z);
      exp_t r;
      int v, q, rem, half;
      v   = int'(m);
      q   = v >> sh;
      rem = v % (1 << sh);
      r.d_tr = q[7:0];
      r.s    = (rem != 0);
      r.z    = 1'b0;
      if (sh > 0) begin
         half = 1 << (sh - 1);
         if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      end
      r.d_rn = q[7:0];
      if (z) begin
         r.d_tr = 8'h00;
         r.d_rn = 8'h00;
         r.s    = 1'b0;
         r.z    = 1'b1;
      end
      return r;
   endfunction

   exp_t       sb[$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_d0, prev_d1;

   // Monitor on the falling edge: handshake is settled, next transfer happens at the rise.
   always @(negedge clk) begin
      if (rst_n) begin
         exp_t e;
         chk("vld_match", vld1, vld0);
         chk("in_ready", rdy0, !(sb.size() == 2 && !out_ready));
         chk("in_ready_rne", rdy1, rdy0);
         if (prev_stall) begin
            chk("hold_vld", vld0, 1);
            chk("hold_d0", dat0, prev_d0);
            chk("hold_d1", dat1, prev_d1);
         end
         if (vld0 && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", 1, 0);
            else begin
               e = sb.pop_front();
               chk("d_trunc", dat0, e.d_tr);
               chk("s_trunc", stk0, e.s);
               chk("z_trunc", zro0, e.z);
               chk("d_rne", dat1, e.d_rn);
               chk("s_rne", stk1, e.s);
               chk("z_rne", zro1, e.z);
            end
         end
         if (in_valid && rdy0) sb.push_back(model(in_mant, int'(in_shift), in_zero));
         prev_stall = vld0 && !out_ready;
         prev_d0    = dat0;
         prev_d1    = dat1;
      end
   end

   // Single beat with out_ready=1: absent one cycle after acceptance, present after two.
   task automatic directed(input logic [7:0] m, input logic [2:0] sh, input logic z,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic es, input logic ez);
      @(posedge clk); #1;
      in_valid = 1'b1; in_mant = m; in_shift = sh; in_zero = z;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat1_vld", vld0, 0);
      @(posedge clk); #1;
      chk("lat2_vld", vld0, 1);
      chk("dir_d_trunc", dat0, e0);
      chk("dir_d_rne", dat1, e1);
      chk("dir_sticky", stk0, es);
      chk("dir_zero", zro0, ez);
   endtask

   initial begin
      #12;
      chk("rst_vld", vld0, 0);
      chk("rst_data", dat0, 0);
      chk("rst_sticky", stk0, 0);
      chk("rst_zero", zro0, 0);
      chk("rst_in_ready", rdy0, 1);
      @(negedge clk); rst_n = 1'b1;

      directed(8'hB5, 3'd3, 1'b0, 8'h16, 8'h17, 1'b1, 1'b0);
      directed(8'h0C, 3'd3, 1'b0, 8'h01, 8'h02, 1'b1, 1'b0);
      directed(8'h14, 3'd3, 1'b0, 8'h02, 8'h02, 1'b1, 1'b0);
      directed(8'hFF, 3'd7, 1'b0, 8'h01, 8'h02, 1'b1, 1'b0);
      directed(8'h80, 3'd0, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0);
      directed(8'hFF, 3'd5, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
      directed(8'hC3, 3'd4, 1'b0, 8'h0C, 8'h0C, 1'b1, 1'b0);

      // Back-to-back burst: 16 accepted beats give 16 consecutive valid cycles.
      out_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         @(posedge clk); #1;
         in_valid = (c < 16);
         in_mant  = 8'h80 | 8'($urandom_range(0, 127));
         in_shift = 3'($urandom_range(0, 7));
         in_zero  = 1'b0;
         if (c >= 2) chk("b2b_vld", vld0, 1);
      end
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("b2b_drain", sb.size(), 0);

      // Random stalls on both sides.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         in_mant   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (8'h80 | 8'($urandom_range(0, 127)));
         in_shift  = 3'($urandom_range(0, 7));
         in_zero   = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 1) == 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("rand_drain", sb.size(), 0);

      // Reset with two beats parked in the pipe.
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_mant = 8'hA0 + 8'(c); in_shift = 3'd1; in_zero = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("full_vld", vld0, 1);
      chk("full_in_ready", rdy0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld", vld0, 0);
      chk("arst_vld_rne", vld1, 0);
      chk("arst_data", dat0, 0);
      sb.delete();
      prev_stall = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("post_rst_vld", vld0, 0);
      end

      directed(8'h9B, 3'd2, 1'b0, 8'h26, 8'h27, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
